// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: register map shared by the timer, the top-level read mux and
// software test headers. Offsets are word offsets within the 8-word block.
package dmem_mmio_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFF_W    = 3;
  localparam int unsigned PCNT_W   = 16;
  localparam int unsigned CTRL_W   = 3;
  localparam int unsigned STATUS_W = 3;

  // Low address bits that select a register inside the block
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [OFF_W-1:0] {
    OFF_CTRL    = 3'd0,
    OFF_COUNT   = 3'd1,
    OFF_COMPARE = 3'd2,
    OFF_STATUS  = 3'd3,
    OFF_CAPTURE = 3'd4
  } reg_off_e;

  // CTRL bit indices
  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_AUTORELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;

  // STATUS bit indices (all sticky, write-1-to-clear)
  localparam int unsigned STATUS_MATCH    = 0;
  localparam int unsigned STATUS_OVERFLOW = 1;
  localparam int unsigned STATUS_CAPTURE  = 2;

  // True when addr falls in the 8-word block starting at base
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base);
    return (addr & ~OFF_MASK) == (base & ~OFF_MASK);
  endfunction

endpackage

// File: rtl/dmem_mmio_timer_if.sv
// dmem_mmio_timer_if: processor data-memory port as seen by an MMIO responder.
//   address (12b word address), data (32b write data), wren -> responder
//   q (32b registered read data), hit (q valid for a decoded access) <- responder
interface dmem_mmio_timer_if;
  import dmem_mmio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q;
  logic              hit;

  modport master (output address, data, wren, input q, hit);
  modport slave  (input address, data, wren, output q, hit);

endinterface

// File: rtl/mmio_prescaler.sv
// mmio_prescaler: divides the clock into count ticks, one every PRESCALE cycles
// while enabled.
//   clock, reset : clock and synchronous active-high reset
//   en_i         : CTRL.en as currently registered
//   clr_i        : a CTRL write clearing en is landing this edge
//   tick_c       : combinational tick, high on the last cycle of each period
module mmio_prescaler
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c
);

  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  assign tick_c = en_i && (pcnt_q == PCNT_MAX);

  // Held at zero while disabled so re-enabling always starts a full period
  always_comb begin
    pcnt_d = pcnt_q;
    if (!en_i || clr_i || tick_c) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_timer.sv
// dmem_mmio_timer: memory-mapped prescaled 32-bit timer on the dmem bus.
//   clock, reset : clock and synchronous active-high reset
//   capture_in   : async capture strobe (only with DMEM_MMIO_TIMER_CAPTURE_EN)
//   bus          : dmem responder port (address/data/wren in, q/hit out)
//   irq          : level interrupt, STATUS.match && CTRL.irq_en
// Registers: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS, 4 CAPTURE (optional).
// Define DMEM_MMIO_TIMER_CAPTURE_EN to build the input-capture feature.
module dmem_mmio_timer
  import dmem_mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hFF0,
  parameter int unsigned       PRESCALE  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
  input  logic                  capture_in,
`endif
  dmem_mmio_timer_if.slave      bus,
  output logic                  irq
);

  logic [OFF_W-1:0]    offset;
  logic                sel;
  logic                wr_en, wr_ctrl, wr_count, wr_compare, wr_status;
  logic                tick;

  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   compare_q, compare_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [STATUS_W-1:0] status_set, status_clr;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   rd_val;
  logic                set_match, set_ovf;

  // Address decode
  assign sel        = addr_hit(bus.address, BASE_ADDR);
  assign offset     = bus.address[OFF_W-1:0];
  assign wr_en      = sel && bus.wren;
  assign wr_ctrl    = wr_en && (offset == OFF_CTRL);
  assign wr_count   = wr_en && (offset == OFF_COUNT);
  assign wr_compare = wr_en && (offset == OFF_COMPARE);
  assign wr_status  = wr_en && (offset == OFF_STATUS);

  mmio_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .en_i   (ctrl_q[CTRL_EN]),
    .clr_i  (wr_ctrl && !bus.data[CTRL_EN]),
    .tick_c (tick)
  );

`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
  logic              cap_meta_q, cap_sync_q, cap_prev_q;
  logic              cap_edge;
  logic [DATA_W-1:0] capture_q, capture_d;

  // Rising edge after the 2-flop synchronizer; latches the pre-update COUNT
  assign cap_edge  = cap_sync_q && !cap_prev_q;
  assign capture_d = cap_edge ? count_q : capture_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_meta_q <= 1'b0;
      cap_sync_q <= 1'b0;
      cap_prev_q <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_meta_q <= capture_in;
      cap_sync_q <= cap_meta_q;
      cap_prev_q <= cap_sync_q;
      capture_q  <= capture_d;
    end
  end
`endif

  // COUNT update: a software write overrides the tick and suppresses flags
  always_comb begin
    count_d   = count_q;
    set_match = 1'b0;
    set_ovf   = 1'b0;
    if (wr_count) begin
      count_d = bus.data;
    end else if (tick) begin
      set_match = (count_q == compare_q);
      if (set_match && ctrl_q[CTRL_AUTORELOAD]) begin
        count_d = '0;
      end else begin
        count_d = count_q + DATA_W'(1);
        set_ovf = (count_q == '1);
      end
    end
  end

  // Sticky flags: hardware set wins over a coincident W1C
  always_comb begin
    status_set                  = '0;
    status_set[STATUS_MATCH]    = set_match;
    status_set[STATUS_OVERFLOW] = set_ovf;
`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
    status_set[STATUS_CAPTURE]  = cap_edge;
`else
    status_set[STATUS_CAPTURE]  = 1'b0;
`endif
    status_clr = wr_status ? bus.data[STATUS_W-1:0] : '0;
    status_d   = (status_q & ~status_clr) | status_set;
  end

  // Remaining register writes
  always_comb begin
    ctrl_d    = wr_ctrl    ? bus.data[CTRL_W-1:0] : ctrl_q;
    compare_d = wr_compare ? bus.data             : compare_q;
  end

  // Read mux sees pre-edge register values
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_CTRL:    rd_val = DATA_W'(ctrl_q);
      OFF_COUNT:   rd_val = count_q;
      OFF_COMPARE: rd_val = compare_q;
      OFF_STATUS:  rd_val = DATA_W'(status_q);
`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
      OFF_CAPTURE: rd_val = capture_q;
`else
      OFF_CAPTURE: rd_val = '0;
`endif
      default:     rd_val = '0;
    endcase
    q_d   = sel ? rd_val : '0;
    hit_d = sel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= '0;
      q_q       <= '0;
      hit_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      q_q       <= q_d;
      hit_q     <= hit_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.hit = hit_q;
  assign irq     = status_q[STATUS_MATCH] && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: doc/dmem_mmio_timer.md
Name: dmem_mmio_timer

Overview:
- Memory-mapped timer peripheral on the data-memory bus. It acts as the responder to the processor's data-memory port: address 12b, write data 32b, wren, read data 32b.
- Sits beside dmem. A top-level mux selects its read data when its hit flag is high.
- Provides a prescaled 32-bit up-counter, a compare match with optional auto-reload, sticky status flags and an interrupt line.

Parameters:
- BASE_ADDR, 12'hFF0, word address of register 0; must be 8-aligned (low 3 bits zero).
- PRESCALE, 4, number of clock cycles per count tick; legal range 1..65535.

Ports:
- clock  in  1  Single system clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- address  in  12  Word address from the processor data port.
- data  in  32  Write data.
- wren  in  1  Write enable.
- q  out  32  Registered read data.
- hit  out  1  Registered; high when q is valid for a decoded register access.
- irq  out  1  Interrupt request, level.

Behaviour:
- Decode:
  - sel = (address[11:3] == BASE_ADDR[11:3]); offset = address[2:0].
  - Registers: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS. Offsets 4-7 read 0 and ignore writes.
- CTRL bits: [0] en, [1] autoreload, [2] irq_en; bits [31:3] read 0.
- STATUS bits: [0] match, [1] overflow. Both are sticky and write-1-to-clear.
- Read latency is 1 cycle, matching the syncram timing:
  - At edge N, q <= selected register value if sel, else 0; hit <= sel.
  - Reads return register values as they stood before edge N's updates.
- Write: when sel && wren, the addressed register updates at the edge. Reads on the same edge return the old value.
- Prescaler:
  - 16-bit pcnt counts 0..PRESCALE-1 while en=1.
  - tick = en && (pcnt == PRESCALE-1); pcnt wraps to 0 on tick.
  - When en=0, pcnt is held at 0.
  - PRESCALE=1 produces a tick every cycle while enabled.
- On tick:
  - If COUNT == COMPARE: set match. COUNT <= 0 if autoreload, else COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - Increment is modulo 2^32. A wrap from 32'hFFFFFFFF to 0 sets overflow.
- irq = match && irq_en. It is combinational from the registers and has no extra latency.
- Priority on simultaneous events:
  - A software write to COUNT beats the tick update, and no match or overflow is set that cycle.
  - A W1C to STATUS in the same cycle as a hardware set: the set wins.
  - A write to CTRL that clears en also resets pcnt to 0 in the same edge.
  - A write to COMPARE takes effect from the next cycle's comparison.
- Reset (synchronous, highest priority): CTRL, COUNT, COMPARE, STATUS, pcnt, q, hit and irq all go to 0. Reset mid-count discards all state.

Optional Feature:
- Macro: DMEM_MMIO_TIMER_CAPTURE_EN.
- Defined:
  - Adds input port capture_in (1b), a 2-flop synchronizer, and a CAPTURE register at offset 4 (read-only).
  - A synchronized rising edge latches COUNT into CAPTURE and sets STATUS[2] (W1C).
  - A capture edge coincident with a COUNT update latches the pre-update COUNT.
- Undefined: no port; offset 4 reads 0; STATUS[2] reads 0.

Decomposition:
- Shared package dmem_mmio_pkg: register offset constants (OFF_CTRL=0, OFF_COUNT=1, OFF_COMPARE=2, OFF_STATUS=3, OFF_CAPTURE=4) and CTRL/STATUS bit-index constants. The package is reused by the top-level read mux and by software test headers.
- Sub-module: mmio_prescaler, containing pcnt, the en-clear logic and the tick output. The counter, compare, status and bus logic stay in the parent.

Test Plan:
- Reset then read offsets 0-3 -> q=0 with hit=1 one cycle after each address. A read at address 12'h000 -> hit=0, q=0.
- PRESCALE=4; write COMPARE=3, CTRL=3'b101 -> COUNT reaches 3 after 12 cycles. On the next tick, match=1, irq=1 and COUNT=4 (no autoreload). W1C 1 to STATUS -> irq=0 the next cycle.
- autoreload=1, COMPARE=2, PRESCALE=1 -> COUNT sequence 0,1,2,0,1,2. match stays set and is cleared only by W1C.
- Write COUNT=32'hFFFFFFFF with en=1, PRESCALE=1 -> next tick COUNT=0, STATUS=2'b10. The same cycle a W1C of bit 1 occurs -> overflow remains 1.
- A write to COUNT=100 coincident with a tick -> COUNT=100 exactly, not 101. A write of CTRL en=0 mid-prescale, then en=1 -> the first tick comes exactly PRESCALE cycles later.
- With DMEM_MMIO_TIMER_CAPTURE_EN defined: a pulse on capture_in at COUNT=7 -> CAPTURE=7 (allowing the 2-cycle synchronizer delay) and STATUS[2]=1.
